sub16bit_8421_serial: RTL and testbench
=======================================

Name: sub16bit_8421_serial

Overview:
Digit-serial 8421 (BCD) subtractor. Computes A - B - Bin over 4 BCD digits, one digit per clock, LSD first. It is the inverse-operation companion to the team's 16-bit 8421 adder. It sits beside that adder in the BCD arithmetic datapath and is controlled by a Start/Busy/Done handshake. Invalid BCD operands are detected and flagged.

Parameters:
DIGITS, 4, number of BCD digits; operand width is 4*DIGITS; all latencies below scale with it.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous active-high reset
Start  input  1  request; sampled only while Busy=0
A  input  4*DIGITS  minuend, BCD; sampled with Start
B  input  4*DIGITS  subtrahend, BCD; sampled with Start
Bin  input  1  borrow in; sampled with Start
Busy  output  1  high from the cycle after Start acceptance through the Done cycle
Done  output  1  one-cycle pulse; Y/Bout/Err/Neg are valid from this cycle on
Y  output  4*DIGITS  BCD difference (mod 10^DIGITS, or magnitude with the optional feature)
Bout  output  1  borrow out (1 = A < B + Bin)
Err  output  1  1 = some A or B digit > 9 in the last accepted operation
Neg  output  1  result-negative flag; tied 0 unless SUB8421_SIGNMAG_EN is defined

Behaviour:
- Reset: async. While rst=1, state=IDLE and Busy, Done, Y, Bout, Err, Neg are all 0. Reset during an operation aborts it; no Done is issued.
- States: IDLE -> CHECK -> SUB(k=0..DIGITS-1) -> [COMP(k=0..DIGITS-1)] -> DONE -> IDLE.
- IDLE: Start=1 latches A, B, Bin into internal registers and goes to CHECK. Inputs are not used after this capture.
- CHECK (1 cycle): any nibble of the latched A or B > 9 sets the internal error flag and goes straight to DONE. Otherwise goes to SUB with k=0 and borrow=Bin.
- SUB digit k (1 cycle each):
  - t = a_k - b_k - borrow, computed 5-bit signed.
  - If t < 0: digit = t + 10 and borrow = 1. Else: digit = t and borrow = 0.
  - Store the digit in Y nibble k.
- After the last digit: Bout_int = borrow.
- DONE (1 cycle): Done=1 and Busy=1. Y, Bout, Err and Neg update together in this cycle.
  - On error: Y=0, Bout=0, Neg=0, Err=1.
  - Otherwise: Err=0.
  - Next state is IDLE.
- Outputs hold their values until the next DONE or reset.
- Latency, measured from the rising edge that samples Start (edge 0):
  - valid operands: Done is high in the cycle following edge DIGITS+1 (edge 5 for DIGITS=4);
  - invalid operands: Done follows edge 1;
  - optional COMP pass: adds DIGITS cycles.
- Start while Busy=1 is ignored, including the DONE cycle. Back-to-back throughput is therefore one operation per DIGITS+3 cycles.
- Bin=1 with all-zero operands is a legal borrow-out case: the result wraps to all nines.

Optional Feature:
SUB8421_SIGNMAG_EN
- Defined, and Bout_int=1 with no error:
  - a COMP pass runs over DIGITS cycles, LSD first, replacing Y with its 10's complement (10^DIGITS - Y) digit-serially;
  - Y becomes the magnitude, Neg=1, and Bout still reports 1;
  - Done comes DIGITS cycles later than in the non-borrow case.
- Defined, and no borrow: COMP is skipped and Neg=0.
- Not defined: COMP states do not exist, Y is the mod-10^DIGITS result, and Neg is constant 0.

Test Plan:
- A=16'h5000, B=16'h1234, Bin=0 -> Y=16'h3766, Bout=0, Err=0; Done after edge 5; Busy high edges 1-5.
- A=16'h1000, B=16'h0001 (borrow ripples across 3 digits) -> Y=16'h0999, Bout=0.
- A=16'h1234, B=16'h5000 -> without macro: Y=16'h6234, Bout=1, Neg=0. With macro: Y=16'h3766, Bout=1, Neg=1, Done after edge 9.
- A=0, B=0, Bin=1 -> without macro: Y=16'h9999, Bout=1. With macro: Y=16'h0001, Neg=1.
- A=16'h12A4, B=16'h0001 -> Err=1, Y=0, Bout=0, Done after edge 1. Then a valid request yields Err=0.
- Start pulsed while Busy -> ignored, with only one Done. Assert rst mid-SUB -> all outputs 0 immediately, no Done. The next Start then completes normally.

Source files
------------

// File: rtl/sub16bit_8421_serial.sv
// Digit-serial 8421 (BCD) subtractor: Y = A - B - Bin, one digit per clock, LSD first.
// Start/Busy/Done handshake; operands with a digit > 9 are flagged on Err.
// Optional macro SUB8421_SIGNMAG_EN: a negative result is returned as a magnitude
// (10's complement pass) with Neg=1. Without it, Y is mod 10^DIGITS and Neg is 0.
module sub16bit_8421_serial #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Y,
  output logic                  Bout,
  output logic                  Err,
  output logic                  Neg
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastK = CntW'(DIGITS - 1);

`ifdef SUB8421_SIGNMAG_EN
  typedef enum logic [2:0] {StIdle, StCheck, StSub, StComp, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StCheck, StSub, StDone} state_e;
`endif

  state_e          state_q;
  logic [CntW-1:0] k_q;
  logic [W-1:0]    a_q, b_q;     // shifted right one digit per SUB step
  logic [W-1:0]    diff_q;       // result digits shifted in from the top
  logic            borrow_q;
  logic            busy_q, done_q, bout_q, err_q;
  logic [W-1:0]    y_q;
`ifdef SUB8421_SIGNMAG_EN
  logic            neg_q;
`endif

  logic [3:0]   sub_a, sub_b, digit;
  logic [4:0]   t;
  logic         borrow_n;
  logic [W-1:0] diff_n;
  logic         bad;

  // Shared single-digit BCD subtractor and operand validity check
  always_comb begin
    sub_a = a_q[3:0];
    sub_b = b_q[3:0];
`ifdef SUB8421_SIGNMAG_EN
    // 10's complement pass computes 0 - Y digit by digit
    if (state_q == StComp) begin
      sub_a = 4'd0;
      sub_b = diff_q[3:0];
    end
`endif
    t = {1'b0, sub_a} - {1'b0, sub_b} - {4'd0, borrow_q};
    if (t[4]) begin
      digit    = t[3:0] + 4'd10;
      borrow_n = 1'b1;
    end else begin
      digit    = t[3:0];
      borrow_n = 1'b0;
    end
    diff_n = (diff_q >> 4) | (W'(digit) << (W - 4));
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      y_q      <= '0;
      bout_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef SUB8421_SIGNMAG_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            busy_q   <= 1'b1;
            state_q  <= StCheck;
          end
        end
        StCheck: begin
          k_q <= '0;
          if (bad) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            y_q     <= '0;
            bout_q  <= 1'b0;
            err_q   <= 1'b1;
`ifdef SUB8421_SIGNMAG_EN
            neg_q   <= 1'b0;
`endif
          end else begin
            state_q <= StSub;
          end
        end
        StSub: begin
          a_q      <= a_q >> 4;
          b_q      <= b_q >> 4;
          diff_q   <= diff_n;
          borrow_q <= borrow_n;
          k_q      <= k_q + CntW'(1);
          if (k_q == LastK) begin
`ifdef SUB8421_SIGNMAG_EN
            if (borrow_n) begin
              k_q      <= '0;
              borrow_q <= 1'b0;
              state_q  <= StComp;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
              y_q     <= diff_n;
              bout_q  <= 1'b0;
              err_q   <= 1'b0;
              neg_q   <= 1'b0;
            end
`else
            state_q <= StDone;
            done_q  <= 1'b1;
            y_q     <= diff_n;
            bout_q  <= borrow_n;
            err_q   <= 1'b0;
`endif
          end
        end
`ifdef SUB8421_SIGNMAG_EN
        StComp: begin
          diff_q   <= diff_n;
          borrow_q <= borrow_n;
          k_q      <= k_q + CntW'(1);
          if (k_q == LastK) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            y_q     <= diff_n;
            bout_q  <= 1'b1;
            err_q   <= 1'b0;
            neg_q   <= 1'b1;
          end
        end
`endif
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Y    = y_q;
  assign Bout = bout_q;
  assign Err  = err_q;
`ifdef SUB8421_SIGNMAG_EN
  assign Neg  = neg_q;
`else
  assign Neg  = 1'b0;
`endif

endmodule

// File: tb/tb_sub16bit_8421_serial.sv
// Scoreboard bench for sub16bit_8421_serial: the driver pushes expected results,
// a Done-triggered monitor pops and compares. Honours SUB8421_SIGNMAG_EN.
module tb_sub16bit_8421_serial;

`ifdef SUB8421_SIGNMAG_EN
  localparam bit SM = 1'b1;
`else
  localparam bit SM = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] y;
    logic        bout;
    logic        err;
    logic        neg;
  } exp_t;

  logic        clk, rst, Start, Bin;
  logic [15:0] A, B;
  logic        Busy, Done, Bout, Err, Neg;
  logic [15:0] Y;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  exp_t sb_q[$];

  sub16bit_8421_serial #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Busy  (Busy),
    .Done  (Done),
    .Y     (Y),
    .Bout  (Bout),
    .Err   (Err),
    .Neg   (Neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every Done pulse consumes one expected result
  always @(negedge clk) begin
    if (!rst && Done) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: actual Y=%h Bout=%b Err=%b Neg=%b required no Done",
                 Y, Bout, Err, Neg);
      end else begin
        e = sb_q.pop_front();
        if (Y !== e.y || Bout !== e.bout || Err !== e.err || Neg !== e.neg) begin
          failures++;
          $display("FAIL result: actual Y=%h Bout=%b Err=%b Neg=%b required Y=%h Bout=%b Err=%b Neg=%b",
                   Y, Bout, Err, Neg, e.y, e.bout, e.err, e.neg);
        end
      end
    end
  end

  // Issue one operation, push its expectation, check Busy and Done latency.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic [15:0] ey, input logic eb,
                        input logic ee, input logic en, input int lat);
    int n;
    @(negedge clk);
    A = a; B = b; Bin = bin; Start = 1'b1;
    sb_q.push_back('{y: ey, bout: eb, err: ee, neg: en});
    @(posedge clk); #1;
    Start = 1'b0;
    check({name, "_busy_start"}, 32'(Busy), 32'd1);
    n = 0;
    while (!Done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    @(posedge clk); #1;
    check({name, "_busy_end"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int d0, n;
    rst = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    #12;
    check("reset_outs", {Busy, Done, Bout, Err, Neg, 11'd0, Y}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic",  16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b0, 1'b0, 1'b0, 5);
    run_op("ripple", 16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0, 1'b0, 5);
    run_op("neg",    16'h1234, 16'h5000, 1'b0, SM ? 16'h3766 : 16'h6234, 1'b1, 1'b0, SM,
           SM ? 9 : 5);
    run_op("wrap",   16'h0000, 16'h0000, 1'b1, SM ? 16'h0001 : 16'h9999, 1'b1, 1'b0, SM,
           SM ? 9 : 5);
    run_op("badbcd", 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
    run_op("binvld", 16'h9876, 16'h1234, 1'b1, 16'h8641, 1'b0, 1'b0, 1'b0, 5);
    run_op("zero",   16'h0999, 16'h0999, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5);

    // Start held high while Busy (including the Done cycle) must be ignored
    d0 = done_cnt;
    @(negedge clk);
    A = 16'h5000; B = 16'h1234; Bin = 1'b0; Start = 1'b1;
    sb_q.push_back('{y: 16'h3766, bout: 1'b0, err: 1'b0, neg: 1'b0});
    @(posedge clk); #1;
    A = 16'h9999; B = 16'h0000;
    n = 0;
    while (!Done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_ignore_latency", 32'(n), 32'd5);
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy_ignore_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset in the middle of SUB aborts with all outputs cleared and no Done
    d0 = done_cnt;
    @(negedge clk);
    A = 16'h4321; B = 16'h1111; Bin = 1'b0; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset_outs", {Busy, Done, Bout, Err, Neg, 11'd0, Y}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);

    run_op("after_rst", 16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0, 1'b0, 5);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
